// File: rtl/log2_pkg.sv
// Shared constants and decoded-entry type for the log2 encoder/decoder pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package log2_pkg;

   localparam int LOG2_W     = 10;  // decoded word width; legal codes 0..LOG2_W-1
   localparam int LOG2_CW    = 4;   // code width, >= clog2(LOG2_W)
   localparam int LOG2_CNT_W = 16;  // statistics counter width

   // One buffered decode result
   typedef struct packed {
      logic [LOG2_W-1:0] onehot;
      logic [LOG2_W-1:0] mask;
      logic              zero;
      logic              err;
   } log2_entry_t;

endpackage

// File: rtl/log2_prio_enc.sv
// Highest-set-bit encoder W->CW with a single-hot flag (exactly one bit set).
// Latency: combinational.
// Backpressure: none; pure function of the input vector.
module log2_prio_enc
   import log2_pkg::*;
#(
   parameter int W  = LOG2_W,
   parameter int CW = LOG2_CW
) (
   input  logic [W-1:0]  vec,
   output logic [CW-1:0] code,
   output logic          single
);

   localparam int PW = $clog2(W + 1);

   logic [PW-1:0] cnt;

   // Scan upward so the last set bit seen wins; count set bits alongside
   always_comb begin
      code = '0;
      cnt  = '0;
      for (int i = 0; i < W; i++) begin
         if (vec[i]) begin
            code = CW'(i);
            cnt  = cnt + PW'(1);
         end
      end
      single = (cnt == PW'(1));
   end

endmodule

// File: rtl/log2_code_decoder.sv
// Expands a log2 code into onehot/mask via a 2-entry buffer, re-encodes each stored entry and counts mismatches.
// Latency: 1 cycle from accept to head when the buffer is empty; one result per cycle sustained.
// Backpressure: in_ready = occupancy < 2 from registered state; outputs hold while out_valid & ~out_ready.
module log2_code_decoder
   import log2_pkg::*;
#(
   parameter int CNT_W = LOG2_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LOG2_CW-1:0] in_code,
   input  logic              in_zero,
   input  logic [LOG2_W-1:0] fault_inj,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LOG2_W-1:0] out_onehot,
   output logic [LOG2_W-1:0] out_mask,
   output logic              out_zero,
   output logic              out_err,
   output logic [CNT_W-1:0]  mismatch_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  xfer_cnt
);

   localparam int W  = LOG2_W;
   localparam int CW = LOG2_CW;

   log2_entry_t       entry;
   log2_entry_t       mem [2];
   log2_entry_t       head;
   logic              wr_ptr, rd_ptr;
   logic [1:0]        occ;
   logic              accept, xfer;
   logic              legal, mismatch;
   logic [CW-1:0]     enc_code;
   logic              enc_single;

   assign in_ready  = (occ != 2'd2);
   assign out_valid = (occ != 2'd0);
   assign accept    = in_valid & in_ready;
   assign xfer      = out_valid & out_ready;

   // Decode the offered code with precedence zero > illegal > legal; fault mask lands on the stored onehot
   always_comb begin
      entry = '0;
      legal = 1'b0;
      if (in_zero) begin
         entry.zero = 1'b1;
      end else if (in_code >= CW'(W)) begin
         entry.err = 1'b1;
      end else begin
         legal        = 1'b1;
         entry.onehot = W'(1) << in_code;
         entry.mask   = entry.onehot | (entry.onehot - W'(1));
      end
      entry.onehot = entry.onehot ^ fault_inj;
   end

   // Re-encode exactly what will be stored, so a corrupted onehot is caught at store time
   log2_prio_enc #(.W(W), .CW(CW)) u_enc (
      .vec    (entry.onehot),
      .code   (enc_code),
      .single (enc_single)
   );

   assign mismatch = accept & legal & ((enc_code != in_code) | ~enc_single);

   assign head       = mem[rd_ptr];
   assign out_onehot = head.onehot;
   assign out_mask   = head.mask;
   assign out_zero   = head.zero;
   assign out_err    = head.err;

   // Two-entry FIFO: write at wr_ptr on accept, pop at rd_ptr on transfer; reset drops contents
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (xfer) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({accept, xfer})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Saturating statistics counters, at most one increment each per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         mismatch_cnt <= '0;
         err_cnt      <= '0;
         xfer_cnt     <= '0;
      end else begin
         if (mismatch && (mismatch_cnt != '1)) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
         if (accept && entry.err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
         if (xfer && (xfer_cnt != '1)) xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_log2_code_decoder.sv
// Directed bench for log2_code_decoder: vector table plus stall, reset and saturation sequences.
// Latency: n/a.
// Backpressure: drives out_ready explicitly per sequence.
module tb_log2_code_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_code;
   logic        in_zero;
   logic [9:0]  fault_inj;
   logic        out_valid;
   logic        out_ready;
   logic [9:0]  out_onehot;
   logic [9:0]  out_mask;
   logic        out_zero;
   logic        out_err;
   logic [15:0] mismatch_cnt;
   logic [15:0] err_cnt;
   logic [15:0] xfer_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   log2_code_decoder dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_code      (in_code),
      .in_zero      (in_zero),
      .fault_inj    (fault_inj),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_onehot   (out_onehot),
      .out_mask     (out_mask),
      .out_zero     (out_zero),
      .out_err      (out_err),
      .mismatch_cnt (mismatch_cnt),
      .err_cnt      (err_cnt),
      .xfer_cnt     (xfer_cnt)
   );

   typedef struct {
      logic       zero;
      logic [3:0] code;
      logic [9:0] fault;
      logic [9:0] oh;
      logic [9:0] mask;
      logic       ez;
      logic       ee;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Advance one clock and land 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string name, input logic [9:0] oh, input logic [9:0] mask,
                           input logic z, input logic e);
      chk({name, ".valid"},  {31'd0, out_valid}, 32'd1);
      chk({name, ".onehot"}, {22'd0, out_onehot}, {22'd0, oh});
      chk({name, ".mask"},   {22'd0, out_mask},   {22'd0, mask});
      chk({name, ".zero"},   {31'd0, out_zero},   {31'd0, z});
      chk({name, ".err"},    {31'd0, out_err},    {31'd0, e});
   endtask

   initial begin
      vecs[0]  = '{1'b0, 4'd0,  10'h000, 10'h001, 10'h001, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 4'd1,  10'h000, 10'h002, 10'h003, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 4'd2,  10'h000, 10'h004, 10'h007, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 4'd3,  10'h000, 10'h008, 10'h00F, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 4'd4,  10'h000, 10'h010, 10'h01F, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 4'd5,  10'h000, 10'h020, 10'h03F, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 4'd6,  10'h000, 10'h040, 10'h07F, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 4'd7,  10'h000, 10'h080, 10'h0FF, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 4'd8,  10'h000, 10'h100, 10'h1FF, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 4'd9,  10'h000, 10'h200, 10'h3FF, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 4'd5,  10'h000, 10'h000, 10'h000, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 4'd10, 10'h000, 10'h000, 10'h000, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 4'd15, 10'h000, 10'h000, 10'h000, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 4'd5,  10'h004, 10'h024, 10'h03F, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 4'd2,  10'h004, 10'h000, 10'h007, 1'b0, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_code   = 4'd0;
      in_zero   = 1'b0;
      fault_inj = 10'h000;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst.in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst.onehot",    {22'd0, out_onehot}, 32'd0);
      chk("rst.mask",      {22'd0, out_mask},   32'd0);
      chk("rst.zero_err",  {30'd0, out_zero, out_err}, 32'd0);
      chk("rst.cnts",      {mismatch_cnt, err_cnt ^ xfer_cnt}, 32'd0);

      // Vector table streamed one per cycle; head after each edge is the previous vector
      for (int k = 0; k <= 15; k++) begin
         if (k > 0) begin
            chk_head($sformatf("vec%0d", k - 1), vecs[k-1].oh, vecs[k-1].mask,
                     vecs[k-1].ez, vecs[k-1].ee);
            chk($sformatf("vec%0d.in_ready", k - 1), {31'd0, in_ready}, 32'd1);
         end
         if (k == 10) begin
            chk("stream.xfer_cnt", {16'd0, xfer_cnt}, 32'd9);
            chk("stream.mismatch", {16'd0, mismatch_cnt}, 32'd0);
         end
         if (k < 15) begin
            in_valid  = 1'b1;
            in_code   = vecs[k].code;
            in_zero   = vecs[k].zero;
            fault_inj = vecs[k].fault;
         end else begin
            in_valid  = 1'b0;
            fault_inj = 10'h000;
            in_zero   = 1'b0;
         end
         tick();
      end
      chk("table.drained",  {31'd0, out_valid}, 32'd0);
      chk("table.xfer_cnt", {16'd0, xfer_cnt}, 32'd15);
      chk("table.err_cnt",  {16'd0, err_cnt}, 32'd2);
      chk("table.mismatch", {16'd0, mismatch_cnt}, 32'd2);

      // Stall: offer 3, 2 accepted, head stable, then drain in order
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_code   = 4'd3;
      tick();
      chk("stall.rdy1", {31'd0, in_ready}, 32'd1);
      chk_head("stall.h1", 10'h008, 10'h00F, 1'b0, 1'b0);
      in_code = 4'd4;
      tick();
      chk("stall.rdy2", {31'd0, in_ready}, 32'd0);
      chk_head("stall.h2", 10'h008, 10'h00F, 1'b0, 1'b0);
      in_code = 4'd6;
      tick();
      chk("stall.rdy3", {31'd0, in_ready}, 32'd0);
      chk_head("stall.h3", 10'h008, 10'h00F, 1'b0, 1'b0);
      tick();
      chk_head("stall.h4", 10'h008, 10'h00F, 1'b0, 1'b0);
      out_ready = 1'b1;
      tick();
      chk("stall.rdy_rel", {31'd0, in_ready}, 32'd1);
      chk_head("drain.c4", 10'h010, 10'h01F, 1'b0, 1'b0);
      tick();
      chk_head("drain.c6", 10'h040, 10'h07F, 1'b0, 1'b0);
      in_valid = 1'b0;
      tick();
      chk("drain.empty", {31'd0, out_valid}, 32'd0);
      chk("drain.xfer_cnt", {16'd0, xfer_cnt}, 32'd18);

      // Reset with the buffer full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_code   = 4'd12;
      tick();
      tick();
      chk("full.in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst.out_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst.in_ready",  {31'd0, in_ready},  32'd1);
      chk("mrst.onehot",    {22'd0, out_onehot}, 32'd0);
      chk("mrst.err_cnt",   {16'd0, err_cnt}, 32'd0);
      chk("mrst.xfer_cnt",  {16'd0, xfer_cnt}, 32'd0);
      chk("mrst.mismatch",  {16'd0, mismatch_cnt}, 32'd0);

      // Long illegal stream drives err_cnt into saturation
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_code   = 4'd15;
      for (int n = 0; n < 100; n++) tick();
      chk("sat.err100", {16'd0, err_cnt}, 32'd100);
      for (int n = 100; n < 65540; n++) tick();
      chk("sat.err_cnt",  {16'd0, err_cnt}, 32'h0000FFFF);
      chk("sat.xfer_cnt", {16'd0, xfer_cnt}, 32'h0000FFFF);
      chk("sat.mismatch", {16'd0, mismatch_cnt}, 32'd0);
      tick();
      chk("sat.hold", {16'd0, err_cnt}, 32'h0000FFFF);
      in_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
